// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: N-digit multiplexed 7-segment driver with sequential shift-add-3 BCD conversion.
// Optional: define SEG7_LZ_BLANK_EN to blank leading zero digits.
module seg7_scan_driver #(
  parameter int WIDTH       = 14,
  parameter int DIGITS      = 4,
  parameter int SCAN_PERIOD = 1000,
  parameter int BLANK_LEAD  = 100,
  parameter int BLANK_TAIL  = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_value,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(SCAN_PERIOD);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int NW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(SCAN_PERIOD - 1);
  localparam logic [CW-1:0] C_ON   = CW'(BLANK_LEAD);
  localparam logic [CW-1:0] C_OFF  = CW'(SCAN_PERIOD - BLANK_TAIL);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0] work, adj;
  logic [NW-1:0] it;
  logic ovf, take, last;

  assign take = in_valid && in_ready;
  assign last = state == SHIFT && it == N_LAST;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    in_ready = state == IDLE;
    state_nxt = state == IDLE ? (in_valid ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  end

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = work[4*i +: 4] >= 4'd5 ? work[4*i +: 4] + 4'd3 : work[4*i +: 4];
  end

  // A 1 leaving the top nibble means the value needs more digits than we have.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bin <= '0;
      work <= '0;
      it <= '0;
      ovf <= 1'b0;
      bcd <= '0;
      overflow <= 1'b0;
    end else if (take) begin
      bin <= in_value;
      work <= '0;
      it <= '0;
      ovf <= 1'b0;
    end else if (state == SHIFT) begin
      {work, bin} <= {adj[BW-2:0], bin, 1'b0};
      ovf <= ovf | adj[BW-1];
      it <= it + 1'b1;
      if (last) begin
        bcd <= {adj[BW-2:0], bin[WIDTH-1]};
        overflow <= ovf | adj[BW-1];
      end
    end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: glyph = 7'h40;
      4'd1: glyph = 7'h79;
      4'd2: glyph = 7'h24;
      4'd3: glyph = 7'h30;
      4'd4: glyph = 7'h19;
      4'd5: glyph = 7'h12;
      4'd6: glyph = 7'h02;
      4'd7: glyph = 7'h78;
      4'd8: glyph = 7'h00;
      4'd9: glyph = 7'h10;
      default: glyph = 7'h7F;
    endcase
  endfunction

  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [DIGITS-1:0] lz;
  logic [6:0] glyph_nxt;

`ifdef SEG7_LZ_BLANK_EN
  logic lz_run;
  always_comb begin
    lz = '0;
    lz_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz_run = lz_run && bcd[4*i +: 4] == 4'd0;
      lz[i] = lz_run;
    end
  end
`else
  assign lz = '0;
`endif

  assign cnt_nxt = cnt == C_LAST ? '0 : cnt + 1'b1;
  assign idx_nxt = cnt == C_LAST ? (idx == I_LAST ? '0 : idx + 1'b1) : idx;
  assign glyph_nxt = overflow ? 7'h3F : lz[idx_nxt] ? 7'h7F : glyph(bcd[4*idx_nxt +: 4]);

  // Display state is latched only at window edges, so bcd updates never glitch a lit slot.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      an <= '1;
      seg <= 7'h7F;
      dp <= 1'b1;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      if (cnt_nxt == C_ON) begin
        an <= ~(DIGITS'(1) << idx_nxt);
        seg <= glyph_nxt;
        dp <= ~dp_mask[idx_nxt];
      end else if (cnt_nxt == C_OFF) begin
        an <= '1;
        seg <= 7'h7F;
        dp <= 1'b1;
      end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver (conversion results and scan windows).
module tb_seg7_scan_driver;
  localparam int W = 14;
  localparam int D = 4;
  logic clk = 0, rst_n = 1, in_valid = 0;
  logic in_ready, overflow, dp;
  logic [W-1:0] in_value = '0;
  logic [D-1:0] dp_mask = '0;
  logic [15:0] bcd;
  logic [6:0] seg;
  logic [3:0] an;

  always #5 clk = ~clk;

  seg7_scan_driver #(.WIDTH(W), .DIGITS(D), .SCAN_PERIOD(10), .BLANK_LEAD(2), .BLANK_TAIL(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .dp_mask(dp_mask), .overflow(overflow), .bcd(bcd), .seg(seg), .dp(dp), .an(an)
  );

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {logic [15:0] bcd; logic ovf; int done;} exp_t;
  exp_t q[$];
  exp_t e;
  logic prev_rdy = 1;
  logic [16:0] snap = '0;
  bit stable = 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!in_ready && {overflow, bcd} !== snap) stable = 0;
      if (in_ready && !prev_rdy) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("bcd", bcd, e.bcd);
          chk("overflow", overflow, e.ovf);
          chk("latency", cyc, e.done);
          chk("stable_mid_conv", stable, 1);
        end
        stable = 1;
      end
      if (in_ready) snap = {overflow, bcd};
    end
    prev_rdy = in_ready;
  end

  logic [6:0] exp_seg[4];
  logic exp_dp[4];
  bit armed = 0, in_win = 0, have_prev = 0, have_blank = 0, wstable = 1;
  int wins = 0, wlen = 0, blen = 0, prev_d = 0, d = 0;
  logic [11:0] cur = '0;

  always @(negedge clk) begin
    if (!armed) begin
      in_win = 0;
      have_prev = 0;
      have_blank = 0;
    end else if (an != 4'hF) begin
      if (!in_win) begin
        d = -1;
        for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) d = i;
        chk("anode_onehot", d >= 0, 1);
        if (d >= 0) begin
          chk($sformatf("seg_d%0d", d), seg, exp_seg[d]);
          chk($sformatf("dp_d%0d", d), dp, exp_dp[d]);
          if (have_prev) chk("digit_order", d, (prev_d + 1) % 4);
          prev_d = d;
          have_prev = 1;
        end
        if (have_blank) chk("blank_len", blen, 4);
        in_win = 1;
        wlen = 1;
        wstable = 1;
        cur = {an, seg, dp};
      end else begin
        wlen++;
        if ({an, seg, dp} != cur) wstable = 0;
      end
    end else if (in_win) begin
      chk("window_len", wlen, 6);
      chk("window_stable", wstable, 1);
      in_win = 0;
      blen = 1;
      have_blank = 1;
      wins++;
    end else blen++;
  end

  task automatic offer(input logic [W-1:0] v, input logic [15:0] eb, input logic eo, input bit push, input bit keep);
    int n = 0;
    @(negedge clk);
    in_value = v;
    in_valid = 1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("offer_timeout", 0, 1);
    if (push) q.push_back('{eb, eo, cyc + 1 + W});
    @(posedge clk);
    #1;
    if (!keep) in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic show(input logic [6:0] s0, s1, s2, s3, input logic [3:0] m, input int nwin);
    int n = 0, base;
    armed = 0;
    dp_mask = m;
    exp_seg = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) exp_dp[i] = ~m[i];
    @(negedge clk);
    while (an != 4'hF && n < 50) begin
      @(negedge clk);
      n++;
    end
    armed = 1;
    base = wins;
    n = 0;
    while (wins < base + nwin && n < nwin * 12 + 24) begin
      @(negedge clk);
      n++;
    end
    if (wins < base + nwin) chk("scan_timeout", 0, 1);
    armed = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    #10;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_an", an, 4'hF);
    @(negedge clk) rst_n = 1;

    offer(1682, 16'h1682, 0, 1, 0);
    wait_idle();
    show(7'h24, 7'h00, 7'h02, 7'h79, 4'b0000, 8);

    offer(9999, 16'h9999, 0, 1, 0);
    wait_idle();
    show(7'h10, 7'h10, 7'h10, 7'h10, 4'b0000, 4);
    offer(10000, 16'h0000, 1, 1, 0);
    wait_idle();
    show(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, 4);
    show(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b1001, 4);

    offer(123, 16'h0123, 0, 1, 1);
    in_value = 5;
    offer(5, 16'h0005, 0, 1, 0);
    wait_idle();

    offer(42, 16'h0042, 0, 1, 0);
    wait_idle();
`ifdef SEG7_LZ_BLANK_EN
    show(7'h24, 7'h19, 7'h7F, 7'h7F, 4'b0000, 4);
`else
    show(7'h24, 7'h19, 7'h40, 7'h40, 4'b0000, 4);
`endif
    offer(0, 16'h0000, 0, 1, 0);
    wait_idle();
`ifdef SEG7_LZ_BLANK_EN
    show(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 4);
    show(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0100, 8);
`else
    show(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 4);
    show(7'h40, 7'h40, 7'h40, 7'h40, 4'b0100, 8);
`endif

    for (int n = 0; an != 4'hF && n < 50; n++) @(negedge clk);
    for (int n = 0; an == 4'hF && n < 50; n++) @(negedge clk);
    offer(1682, 16'h0000, 0, 0, 0);
    chk("pre_rst_busy", in_ready, 0);
    chk("pre_rst_window", an != 4'hF, 1);
    #2 rst_n = 0;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_seg", seg, 7'h7F);
    chk("async_dp", dp, 1);
    chk("async_in_ready", in_ready, 1);
    chk("async_bcd", bcd, 16'h0000);
    chk("async_overflow", overflow, 0);
    @(negedge clk) rst_n = 1;

    offer(77, 16'h0077, 0, 1, 0);
    wait_idle();
`ifdef SEG7_LZ_BLANK_EN
    show(7'h78, 7'h78, 7'h7F, 7'h7F, 4'b0000, 4);
`else
    show(7'h78, 7'h78, 7'h40, 7'h40, 4'b0000, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
